// File: rtl/ex_operand_stage_if.sv
// ID/EX operand stage bus: pipeline control, decoded ID fields, forwarding sources and EX-side results.
interface ex_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int OPW  = 5
);
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rf_rd0;
    logic [XLEN-1:0] id_rf_rd1;
    logic [XLEN-1:0] id_imm;
    logic [REGW-1:0] id_rs0;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rd;
    logic            id_rf_we;
    logic [1:0]      id_src0_sel;
    logic [1:0]      id_src1_sel;
    logic [OPW-1:0]  id_alu_op;
    logic            mem_rf_we;
    logic [REGW-1:0] mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            wb_rf_we;
    logic [REGW-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [REGW-1:0] ex_rd;
    logic            ex_rf_we;
    logic [XLEN-1:0] alu_src0;
    logic [XLEN-1:0] alu_src1;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] ex_store_data;

    modport master (
        output stall, flush, id_valid, id_pc, id_rf_rd0, id_rf_rd1, id_imm,
               id_rs0, id_rs1, id_rd, id_rf_we, id_src0_sel, id_src1_sel, id_alu_op,
               mem_rf_we, mem_rd, mem_data, wb_rf_we, wb_rd, wb_data,
        input  ex_valid, ex_pc, ex_rd, ex_rf_we, alu_src0, alu_src1, alu_op, ex_store_data
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rf_rd0, id_rf_rd1, id_imm,
               id_rs0, id_rs1, id_rd, id_rf_we, id_src0_sel, id_src1_sel, id_alu_op,
               mem_rf_we, mem_rd, mem_data, wb_rf_we, wb_rd, wb_data,
        output ex_valid, ex_pc, ex_rd, ex_rf_we, alu_src0, alu_src1, alu_op, ex_store_data
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU: latches decoded fields, forwards from MEM/WB and muxes ALU operands.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int OPW  = 5
) (
    input logic              clk,
    input logic              rstn,
    ex_operand_stage_if.slave bus
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd0;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs0;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rd;
        logic            rfWe;
        logic [1:0]      src0Sel;
        logic [1:0]      src1Sel;
        logic [OPW-1:0]  aluOp;
    } stage_t;

    stage_t          stage_d;
    stage_t          stage_q;
    logic [XLEN-1:0] fwdRs0;
    logic [XLEN-1:0] fwdRs1;
    logic [XLEN-1:0] src0;
    logic [XLEN-1:0] src1;

    // Flush beats stall; a bubble selects zero for both operands so the ALU sees 0 + 0.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d         = '0;
            stage_d.src0Sel = 2'd2;
            stage_d.src1Sel = 2'd3;
        end else if (!bus.stall) begin
            stage_d.valid   = bus.id_valid;
            stage_d.pc      = bus.id_pc;
            stage_d.rd0     = bus.id_rf_rd0;
            stage_d.rd1     = bus.id_rf_rd1;
            stage_d.imm     = bus.id_imm;
            stage_d.rs0     = bus.id_rs0;
            stage_d.rs1     = bus.id_rs1;
            stage_d.rd      = bus.id_rd;
            stage_d.rfWe    = bus.id_rf_we & bus.id_valid;
            stage_d.src0Sel = bus.id_src0_sel;
            stage_d.src1Sel = bus.id_src1_sel;
            stage_d.aluOp   = bus.id_alu_op;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Forwarding uses live MEM/WB inputs so a held instruction picks up results as producers retire.
    always_comb begin
        fwdRs0 = stage_q.rd0;
        if (bus.mem_rf_we && (bus.mem_rd != '0) && (bus.mem_rd == stage_q.rs0)) begin
            fwdRs0 = bus.mem_data;
        end else if (bus.wb_rf_we && (bus.wb_rd != '0) && (bus.wb_rd == stage_q.rs0)) begin
            fwdRs0 = bus.wb_data;
        end

        fwdRs1 = stage_q.rd1;
        if (bus.mem_rf_we && (bus.mem_rd != '0) && (bus.mem_rd == stage_q.rs1)) begin
            fwdRs1 = bus.mem_data;
        end else if (bus.wb_rf_we && (bus.wb_rd != '0) && (bus.wb_rd == stage_q.rs1)) begin
            fwdRs1 = bus.wb_data;
        end

        case (stage_q.src0Sel)
            2'd0:    src0 = fwdRs0;
            2'd1:    src0 = stage_q.pc;
            default: src0 = '0;
        endcase

        case (stage_q.src1Sel)
            2'd0:    src1 = fwdRs1;
            2'd1:    src1 = stage_q.imm;
            2'd2:    src1 = XLEN'(4);
            default: src1 = '0;
        endcase
    end

    assign bus.ex_valid      = stage_q.valid;
    assign bus.ex_pc         = stage_q.pc;
    assign bus.ex_rd         = stage_q.rd;
    assign bus.ex_rf_we      = stage_q.rfWe & stage_q.valid;
    assign bus.alu_src0      = src0;
    assign bus.alu_src1      = src1;
    assign bus.alu_op        = stage_q.aluOp;
    assign bus.ex_store_data = fwdRs1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed literal cases plus randomized traffic against a record model.
module tb_ex_operand_stage;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    ex_operand_stage_if #(.XLEN(32), .REGW(5), .OPW(5)) bus ();

    ex_operand_stage #(.XLEN(32), .REGW(5), .OPW(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Model: the instruction currently sitting in EX, as a plain record.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] imm;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic [4:0]  op;
    } instr_t;

    instr_t inEx;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inEx <= '0;
        end else if (bus.flush) begin
            inEx <= '{valid: 1'b0, pc: 32'd0, rd0: 32'd0, rd1: 32'd0, imm: 32'd0, rs0: 5'd0,
                      rs1: 5'd0, rd: 5'd0, we: 1'b0, sel0: 2'd2, sel1: 2'd3, op: 5'd0};
        end else if (!bus.stall) begin
            inEx <= '{valid: bus.id_valid, pc: bus.id_pc, rd0: bus.id_rf_rd0, rd1: bus.id_rf_rd1,
                      imm: bus.id_imm, rs0: bus.id_rs0, rs1: bus.id_rs1, rd: bus.id_rd,
                      we: bus.id_rf_we & bus.id_valid, sel0: bus.id_src0_sel,
                      sel1: bus.id_src1_sel, op: bus.id_alu_op};
        end
    end

    function automatic logic [31:0] operandValue(input logic [4:0] rs, input logic [31:0] regData,
                                                  input logic memWe, input logic [4:0] memRd,
                                                  input logic [31:0] memData, input logic wbWe,
                                                  input logic [4:0] wbRd, input logic [31:0] wbData);
        if (rs == 5'd0) return regData;
        if (memWe && memRd == rs) return memData;
        if (wbWe && wbRd == rs) return wbData;
        return regData;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison of every output against the model, half a cycle after each edge.
    always @(negedge clk) begin
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] e0;
        logic [31:0] e1;
        if (rstn) begin
            v0 = operandValue(inEx.rs0, inEx.rd0, bus.mem_rf_we, bus.mem_rd, bus.mem_data,
                              bus.wb_rf_we, bus.wb_rd, bus.wb_data);
            v1 = operandValue(inEx.rs1, inEx.rd1, bus.mem_rf_we, bus.mem_rd, bus.mem_data,
                              bus.wb_rf_we, bus.wb_rd, bus.wb_data);
            e0 = (inEx.sel0 == 2'd0) ? v0 : (inEx.sel0 == 2'd1) ? inEx.pc : 32'd0;
            e1 = (inEx.sel1 == 2'd0) ? v1 : (inEx.sel1 == 2'd1) ? inEx.imm :
                 (inEx.sel1 == 2'd2) ? 32'd4 : 32'd0;
            checkOutput("model ex_valid", 32'(bus.ex_valid), 32'(inEx.valid));
            checkOutput("model ex_pc", bus.ex_pc, inEx.pc);
            checkOutput("model ex_rd", 32'(bus.ex_rd), 32'(inEx.rd));
            checkOutput("model ex_rf_we", 32'(bus.ex_rf_we), 32'(inEx.we && inEx.valid));
            checkOutput("model alu_src0", bus.alu_src0, e0);
            checkOutput("model alu_src1", bus.alu_src1, e1);
            checkOutput("model alu_op", 32'(bus.alu_op), 32'(inEx.op));
            checkOutput("model ex_store_data", bus.ex_store_data, v1);
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] rd0,
                                 input logic [31:0] rd1, input logic [31:0] imm, input logic [4:0] rs0,
                                 input logic [4:0] rs1, input logic [4:0] rd, input logic we,
                                 input logic [1:0] s0, input logic [1:0] s1, input logic [4:0] op);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rf_rd0   = rd0;
        bus.id_rf_rd1   = rd1;
        bus.id_imm      = imm;
        bus.id_rs0      = rs0;
        bus.id_rs1      = rs1;
        bus.id_rd       = rd;
        bus.id_rf_we    = we;
        bus.id_src0_sel = s0;
        bus.id_src1_sel = s1;
        bus.id_alu_op   = op;
    endtask

    task automatic applyRandomId();
        logic [4:0] r0;
        logic [4:0] r1;
        r0 = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        applyStimulus(1'($urandom), $urandom, (r0 == 0) ? 32'd0 : $urandom, (r1 == 0) ? 32'd0 : $urandom,
                      $urandom, r0, r1, 5'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 5'($urandom));
    endtask

    task automatic applyRandomFwd();
        bus.mem_rf_we = 1'($urandom);
        bus.mem_rd    = 5'($urandom_range(0, 7));
        bus.mem_data  = $urandom;
        bus.wb_rf_we  = 1'($urandom);
        bus.wb_rd     = 5'($urandom_range(0, 7));
        bus.wb_data   = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.mem_rf_we = 1'b0;
        bus.mem_rd = '0;
        bus.mem_data = '0;
        bus.wb_rf_we = 1'b0;
        bus.wb_rd = '0;
        bus.wb_data = '0;
        applyRandomId();
        bus.id_valid = 1'b1;

        // Reset holds the stage empty regardless of ID activity.
        repeat (3) step();
        checkOutput("reset ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("reset ex_rf_we", 32'(bus.ex_rf_we), 32'd0);
        checkOutput("reset alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("reset alu_src0", bus.alu_src0, 32'd0);
        checkOutput("reset alu_src1", bus.alu_src1, 32'd0);

        applyStimulus(1'b1, 32'h40, 32'h10, 32'h20, 32'h0, 5'd3, 5'd4, 5'd7, 1'b1, 2'd0, 2'd0, 5'b00010);
        @(negedge clk);
        rstn = 1'b1;
        step();
        checkOutput("rtype alu_src0", bus.alu_src0, 32'h10);
        checkOutput("rtype alu_src1", bus.alu_src1, 32'h20);
        checkOutput("rtype alu_op", 32'(bus.alu_op), 32'b00010);
        checkOutput("rtype ex_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("rtype ex_rf_we", 32'(bus.ex_rf_we), 32'd1);

        applyStimulus(1'b1, 32'h44, 32'h77, 32'h0, 32'h0, 5'd5, 5'd0, 5'd8, 1'b1, 2'd0, 2'd0, 5'b00000);
        step();
        bus.mem_rf_we = 1'b1;
        bus.mem_rd = 5'd5;
        bus.mem_data = 32'hAAAA0000;
        bus.wb_rf_we = 1'b1;
        bus.wb_rd = 5'd5;
        bus.wb_data = 32'h1234;
        #1;
        checkOutput("fwd mem priority", bus.alu_src0, 32'hAAAA0000);
        bus.mem_rf_we = 1'b0;
        #1;
        checkOutput("fwd wb fallback", bus.alu_src0, 32'h1234);

        applyStimulus(1'b1, 32'h48, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9, 1'b1, 2'd0, 2'd0, 5'b00000);
        step();
        bus.wb_rf_we = 1'b0;
        bus.mem_rf_we = 1'b1;
        bus.mem_rd = 5'd0;
        bus.mem_data = 32'hFFFFFFFF;
        #1;
        checkOutput("x0 alu_src1", bus.alu_src1, 32'd0);
        checkOutput("x0 store_data", bus.ex_store_data, 32'd0);

        bus.mem_rf_we = 1'b0;
        applyStimulus(1'b1, 32'h100, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 1'b1, 2'd1, 2'd2, 5'b00000);
        step();
        checkOutput("jal alu_src0", bus.alu_src0, 32'h100);
        checkOutput("jal alu_src1", bus.alu_src1, 32'd4);

        applyStimulus(1'b1, 32'h104, 32'h0, 32'h999, 32'hFFFFFFF8, 5'd0, 5'd9, 5'd0, 1'b0, 2'd0, 2'd1, 5'b00000);
        bus.wb_rf_we = 1'b1;
        bus.wb_rd = 5'd9;
        bus.wb_data = 32'h55;
        step();
        checkOutput("store alu_src1", bus.alu_src1, 32'hFFFFFFF8);
        checkOutput("store data", bus.ex_store_data, 32'h55);

        bus.wb_rf_we = 1'b0;
        applyStimulus(1'b1, 32'h200, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2, 1'b1, 2'd1, 2'd2, 5'b00011);
        step();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyRandomId();
            step();
            checkOutput("stall ex_pc", bus.ex_pc, 32'h200);
            checkOutput("stall alu_op", 32'(bus.alu_op), 32'b00011);
            checkOutput("stall alu_src1", bus.alu_src1, 32'd4);
        end
        bus.flush = 1'b1;
        step();
        checkOutput("flush ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("flush ex_rf_we", 32'(bus.ex_rf_we), 32'd0);
        checkOutput("flush alu_src0", bus.alu_src0, 32'd0);
        checkOutput("flush alu_src1", bus.alu_src1, 32'd0);
        checkOutput("flush alu_op", 32'(bus.alu_op), 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Randomized traffic with occasional mid-stream resets; the negedge compare process checks it.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c % 700 == 699) begin
                rstn = 1'b0;
                #1;
                rstn = 1'b1;
            end
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            applyRandomId();
            applyRandomFwd();
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline stage that feeds the ALU. It latches decoded instruction fields on each advancing clock. It resolves RAW hazards by forwarding results from the MEM and WB stages. It selects the final alu_src0, alu_src1 and alu_op presented to the ALU in the EX cycle. It also carries pc, rd, rf_we and the store-data operand downstream to EX/MEM.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width
OPW, 5, ALU opcode width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
stall  in  1  hold stage contents
flush  in  1  replace incoming instruction with bubble
id_valid  in  1  decode slot holds an instruction
id_pc  in  XLEN  instruction pc
id_rf_rd0  in  XLEN  register file read data, port 0
id_rf_rd1  in  XLEN  register file read data, port 1
id_imm  in  XLEN  sign-extended immediate
id_rs0  in  REGW  source register 0 index
id_rs1  in  REGW  source register 1 index
id_rd  in  REGW  destination index
id_rf_we  in  1  instruction writes rd
id_src0_sel  in  2  0=rs0, 1=pc, 2=zero, 3=zero
id_src1_sel  in  2  0=rs1, 1=imm, 2=constant 4, 3=zero
id_alu_op  in  OPW  ALU opcode (ADD=00000, SUB=00010, PASS=11110, ...)
mem_rf_we  in  1  MEM-stage valid writer
mem_rd  in  REGW  MEM-stage destination
mem_data  in  XLEN  MEM-stage result
wb_rf_we  in  1  WB-stage valid writer
wb_rd  in  REGW  WB-stage destination
wb_data  in  XLEN  WB-stage result
ex_valid  out  1  EX slot holds a real instruction
ex_pc  out  XLEN  latched pc
ex_rd  out  REGW  latched rd
ex_rf_we  out  1  latched rf_we, gated by ex_valid
alu_src0  out  XLEN  ALU operand 0
alu_src1  out  XLEN  ALU operand 1
alu_op  out  OPW  ALU opcode
ex_store_data  out  XLEN  forwarded rs1 value for stores

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low. On rstn=0 every stage register clears to 0, so ex_valid=0, ex_rf_we=0, alu_op=00000 (ADD) and all sel/data regs are 0. Consequently alu_src0 and alu_src1 read 0.
- Update priority at posedge clk: flush > stall > load.
  - flush=1: load bubble. valid=0, rf_we=0, op=ADD, sels=2/3 (zero operands), rd=0, pc=0, data regs=0.
  - flush=0, stall=1: all stage registers hold.
  - Otherwise: latch all id_* fields. rf_we latches id_rf_we & id_valid.
- Latency: one cycle from ID inputs to registered EX fields. Forwarding and operand muxing are combinational from the registered fields and the live mem_*/wb_* inputs. No clock sits between the forwarding inputs and alu_src*.
- Forwarding applies independently for rs0 and rs1:
  - If mem_rf_we and mem_rd != 0 and mem_rd == latched rs, use mem_data.
  - Else if wb_rf_we and wb_rd != 0 and wb_rd == latched rs, use wb_data.
  - Else use the latched rf read data.
  - MEM has priority over WB when both match.
  - Index 0 never forwards; it always uses the latched data, which the register file guarantees is 0.
- Operand select:
  - alu_src0 = fwd_rs0 / ex_pc / 0 / 0 for sel 0/1/2/3.
  - alu_src1 = fwd_rs1 / imm / 32'd4 / 0 for sel 0/1/2/3.
- ex_store_data is always fwd_rs1, regardless of src1_sel.
- alu_op passes through from its register. The block never alters the opcode.
- Stall while a forwarding source retires: the registered rf data are stale, but forwarding re-evaluates every cycle on live inputs. The hazard unit must stall until the producer is in MEM or WB. This block adds no load-use detection.
- Simultaneous stall and flush: flush wins and the bubble is inserted.
- Deasserting rstn mid-stream discards the in-flight instruction. The first instruction after reset requires id_valid=1.
- Widths: all datapath ops are XLEN-bit. The constant 4 is zero-extended.

Test Plan:
- Reset: hold rstn=0 with id_valid=1 and random id_* inputs -> ex_valid=0, ex_rf_we=0, alu_op=00000, alu_src0=alu_src1=0. After release, the first posedge latches the inputs.
- Plain R-type: rs0=3 (rd0=0x10), rs1=4 (rd1=0x20), sel0=0, sel1=0, op=SUB, no forwarding -> next cycle alu_src0=0x10, alu_src1=0x20, alu_op=00010, ex_valid=1.
- Forward priority: latched rs0=5. mem_rf_we=1, mem_rd=5, mem_data=0xAAAA0000. wb_rf_we=1, wb_rd=5, wb_data=0x1234 -> alu_src0=0xAAAA0000. Drop mem_rf_we -> alu_src0=0x1234 in the same cycle.
- x0 guard: rs1=0, rd1=0, mem_rf_we=1, mem_rd=0, mem_data=0xFFFFFFFF -> alu_src1=0 and ex_store_data=0.
- JAL link: pc=0x0000_0100, sel0=1, sel1=2, op=ADD -> alu_src0=0x100, alu_src1=4. Store path with sel1=1, imm=0xFFFFFFF8 and rs1 forwarded from WB=0x55 -> alu_src1=0xFFFFFFF8, ex_store_data=0x55.
- Stall/flush: stall=1 for 3 cycles with changing id_* -> outputs constant. Then assert stall=1 and flush=1 together -> next cycle ex_valid=0, ex_rf_we=0, alu_src0=alu_src1=0, alu_op=00000.
